// File: rtl/rf_write_arbiter.sv
// Merges in-order pipe writeback with buffered out-of-order late results onto one RF write port.
// Optional starvation guard: define RF_WR_STARVE_GUARD_EN to force a blocked FIFO head through.
module rf_write_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_wd,
  output logic        pipe_stall,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_wd,
  input  logic [4:0]  hz_rs1,
  input  logic [4:0]  hz_rs2,
  input  logic [4:0]  hz_rd,
  output logic        hz_pending,
  output logic        WE,
  output logic [4:0]  A3,
  output logic [31:0] WD
);

  localparam int PW = $clog2(DEPTH);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || MAX_WAIT < 1) begin : g_param_check
    $error("rf_write_arbiter: DEPTH must be a power of two in 2..16 and MAX_WAIT >= 1");
  end

  logic [DEPTH-1:0] live_q, live_d;
  logic [4:0]       rd_q [DEPTH];
  logic [31:0]      wd_q [DEPTH];
  logic [PW-1:0]    rptr_q, wptr_q;
  logic [PW:0]      cnt_q, cnt_d;

  logic empty, full, head_live, force_head;
  logic pipe_take, head_sel, pop, push, hz_hit;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == (PW+1)'(DEPTH));
  assign head_live = live_q[rptr_q];

`ifdef RF_WR_STARVE_GUARD_EN
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [WW-1:0] wait_q, wait_d;

  assign force_head = !empty && (wait_q == WW'(MAX_WAIT));

  always_comb begin
    wait_d = wait_q;
    if (pop || empty) wait_d = '0;
    else              wait_d = wait_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) wait_q <= '0;
    else     wait_q <= wait_d;
  end
`else
  assign force_head = 1'b0;
`endif

  // A forced head preempts the pipe; the ignored pipe write applies no kill.
  assign pipe_take = !rst && !force_head && pipe_we && (pipe_rd != 5'd0);
  assign head_sel  = !rst && !empty && (force_head || !pipe_take);
  assign pop       = head_sel || (!rst && !empty && !head_live && pipe_take);
  assign lsu_ready = !rst && !full;
  assign push      = lsu_valid && lsu_ready;
  assign pipe_stall = !rst && force_head;

  always_comb begin
    WE = 1'b0;
    A3 = 5'd0;
    WD = 32'd0;
    if (head_sel) begin
      if (head_live) begin
        WE = 1'b1;
        A3 = rd_q[rptr_q];
        WD = wd_q[rptr_q];
      end
    end else if (pipe_take) begin
      WE = 1'b1;
      A3 = pipe_rd;
      WD = pipe_wd;
    end
  end

  // Younger pipe write wins over any buffered result to the same register.
  always_comb begin
    live_d = live_q;
    if (pipe_take) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rd_q[i] == pipe_rd) live_d[i] = 1'b0;
      end
    end
    if (pop)  live_d[rptr_q] = 1'b0;
    if (push) live_d[wptr_q] = (lsu_rd != 5'd0);
  end

  always_comb begin
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live_q <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      live_q <= live_d;
      cnt_q  <= cnt_d;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push) wptr_q <= wptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wptr_q] <= lsu_rd;
      wd_q[wptr_q] <= lsu_wd;
    end
  end

  always_comb begin
    hz_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (((hz_rs1 != 5'd0) && (rd_q[i] == hz_rs1)) ||
                        ((hz_rs2 != 5'd0) && (rd_q[i] == hz_rs2)) ||
                        ((hz_rd  != 5'd0) && (rd_q[i] == hz_rd)))) begin
        hz_hit = 1'b1;
      end
    end
  end

  assign hz_pending = !rst && hz_hit;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized and directed bench for rf_write_arbiter against a queue-based reference model.
module tb_rf_write_arbiter;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wd;
  logic        pipe_stall;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_wd;
  logic [4:0]  hz_rs1, hz_rs2, hz_rd;
  logic        hz_pending;
  logic        WE;
  logic [4:0]  A3;
  logic [31:0] WD;

  rf_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd), .pipe_stall(pipe_stall),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd),
    .hz_rs1(hz_rs1), .hz_rs2(hz_rs2), .hz_rd(hz_rd), .hz_pending(hz_pending),
    .WE(WE), .A3(A3), .WD(WD)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        live;
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;

  ent_t        mq[$];
  int          mwait;
  logic [31:0] mreg [32];
  logic [31:0] sreg [32];
  int          n_chk  = 0;
  int          n_fail = 0;
  bit          guard_on;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic pwe, input logic [4:0] prd, input logic [31:0] pwd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] lwd);
    pipe_we = pwe; pipe_rd = prd; pipe_wd = pwd;
    lsu_valid = lv; lsu_rd = lrd; lsu_wd = lwd;
  endtask

  function automatic bit hz_match(input logic [4:0] r);
    return (r != 0) && ((r == hz_rs1) || (r == hz_rs2) || (r == hz_rd));
  endfunction

  // One clock: compare outputs against the model, then advance the model at the edge.
  task automatic tick();
    bit          frc, ptake, hsel, popd, rdy, hz;
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    #1;
    e_we = 0; e_a3 = 0; e_wd = 0; frc = 0; ptake = 0; hsel = 0; popd = 0; rdy = 0; hz = 0;
    if (!rst) begin
      frc   = guard_on && (mq.size() > 0) && (mwait == MAX_WAIT);
      ptake = !frc && pipe_we && (pipe_rd != 0);
      hsel  = (mq.size() > 0) && (frc || !ptake);
      if (hsel) begin
        if (mq[0].live) begin e_we = 1; e_a3 = mq[0].rd; e_wd = mq[0].wd; end
      end else if (ptake) begin
        e_we = 1; e_a3 = pipe_rd; e_wd = pipe_wd;
      end
      popd = hsel || ((mq.size() > 0) && !mq[0].live && ptake);
      rdy  = mq.size() < DEPTH;
      foreach (mq[i]) if (mq[i].live && hz_match(mq[i].rd)) hz = 1;
    end
    chk("WE", WE, e_we);
    chk("A3", A3, e_a3);
    chk("WD", WD, e_wd);
    chk("lsu_ready", lsu_ready, rdy);
    chk("hz_pending", hz_pending, hz);
    chk("pipe_stall", pipe_stall, frc);
    if (WE) sreg[A3] = WD;
    if (e_we) mreg[e_a3] = e_wd;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mwait = 0;
    end else begin
      bit was_nonempty;
      was_nonempty = mq.size() > 0;
      if (ptake) foreach (mq[i]) if (mq[i].rd == pipe_rd) mq[i].live = 0;
      if (popd) void'(mq.pop_front());
      if (lsu_valid && rdy) mq.push_back('{live: (lsu_rd != 0), rd: lsu_rd, wd: lsu_wd});
      if (popd || !was_nonempty) mwait = 0;
      else mwait++;
    end
    @(negedge clk);
  endtask

  initial begin
    int stall_at;
    logic [4:0] stall_a3;
`ifdef RF_WR_STARVE_GUARD_EN
    guard_on = 1;
`else
    guard_on = 0;
`endif
    for (int i = 0; i < 32; i++) begin mreg[i] = 0; sreg[i] = 0; end
    mwait = 0;
    rst = 1; hz_rs1 = 0; hz_rs2 = 0; hz_rd = 0;
    drive(1, 5'd6, 32'h1234, 1, 5'd6, 32'h55);
    @(negedge clk);
    tick(); tick();
    rst = 0;

    // Lone pipe write and x0 write.
    drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    #1;
    chk("pipe_we_first", WE, 1);
    chk("pipe_a3_first", A3, 5);
    chk("pipe_wd_first", WD, 32'hDEADBEEF);
    tick();
    drive(1, 5'd0, 32'hFFFF, 0, 0, 0);
    #1; chk("x0_we", WE, 0);
    tick();

    // Late result with idle pipe, hazard visible only while queued.
    hz_rs1 = 5'd7;
    drive(0, 0, 0, 1, 5'd7, 32'h11);
    #1; chk("hz_push_cycle", hz_pending, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("late_we", WE, 1);
    chk("late_a3", A3, 7);
    chk("hz_queued", hz_pending, 1);
    tick();
    #1; chk("hz_after_pop", hz_pending, 0);
    hz_rs1 = 0;

    // Fill twice behind a busy pipe; second fill starts at an offset so pointers wrap.
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        drive(0, 0, 0, 1, 5'd15, 32'h77); tick();
        drive(0, 0, 0, 0, 0, 0); tick();
      end
      for (int k = 0; k < DEPTH; k++) begin
        drive(1, 5'd3, 32'h300 + k, 1, 5'(10 + k), 32'hA0 + k);
        tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      #1; chk("full_ready", lsu_ready, 0);
      for (int k = 0; k < DEPTH; k++) begin
        #1; chk("drain_a3", A3, 10 + k);
        tick();
      end
      #1; chk("ready_after_drain", lsu_ready, 1);
    end

    // WAW kill: queued rd9 overtaken by pipe rd9.
    drive(1, 5'd3, 32'h33, 1, 5'd9, 32'hAA); tick();
    drive(1, 5'd9, 32'hBB, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    #1; chk("killed_head_we", WE, 0);
    tick(); tick();
    chk("reg9_final", sreg[9], 32'hBB);

    // Starvation: head rd4 behind a pipe writing every cycle.
    stall_at = -1; stall_a3 = 0;
    for (int k = 0; k < 12; k++) begin
      drive(1, 5'd3, 32'h3000 + k, (k == 0), 5'd4, 32'h44);
      #1;
      if (pipe_stall && stall_at < 0) begin stall_at = k; stall_a3 = A3; end
      tick();
    end
    if (guard_on) begin
      chk("guard_stall_cycle", stall_at, 9);
      chk("guard_stall_a3", stall_a3, 4);
    end else begin
      chk("noguard_no_stall", stall_at, -1);
    end
    drive(0, 0, 0, 0, 0, 0); tick(); tick();

    // Reset with three entries queued.
    for (int k = 0; k < 3; k++) begin
      drive(1, 5'd3, 32'h3, 1, 5'(20 + k), 32'hC0 + k); tick();
    end
    rst = 1;
    drive(1, 5'd3, 32'h3, 1, 5'd23, 32'hC3);
    #1; chk("rst_we", WE, 0);
    tick();
    rst = 0;
    drive(0, 0, 0, 0, 0, 0);
    hz_rs1 = 5'd20;
    #1;
    chk("post_rst_we", WE, 0);
    chk("post_rst_ready", lsu_ready, 1);
    chk("post_rst_hz", hz_pending, 0);
    for (int k = 0; k < 4; k++) tick();
    for (int k = 20; k < 24; k++) chk("rst_no_write", sreg[k], 0);
    hz_rs1 = 0;

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 9) < 5), 5'($urandom_range(0, 7)), $urandom);
      hz_rs1 = 5'($urandom_range(0, 7));
      hz_rs2 = 5'($urandom_range(0, 7));
      hz_rd  = 5'($urandom_range(0, 7));
      tick();
    end
    rst = 0;
    drive(0, 0, 0, 0, 0, 0);
    hz_rs1 = 0; hz_rs2 = 0; hz_rd = 0;
    for (int k = 0; k < DEPTH + 2; k++) tick();
    for (int i = 0; i < 32; i++) chk($sformatf("regfile[%0d]", i), sreg[i], mreg[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
